// File: rtl/ex_muldiv_unit.sv
// EX-stage multiply/divide unit: owns HI/LO and stalls the front of the pipeline
// while a multi-cycle MULT/MULTU/DIV/DIVU is in flight.
module ex_muldiv_unit #(
  parameter int unsigned MUL_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        md_valid,
  input  logic [5:0]  funct,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        md_stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] mf_result,
  output logic        div_by_zero
);

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t      state;
  logic [4:0]  cnt;
  logic [31:0] opa;       // multiplicand, or dividend shifting into quotient
  logic [31:0] opb;       // multiplier, or divisor magnitude
  logic [31:0] rem;
  logic        mul_signed;
  logic        neg_q;
  logic        neg_r;

  logic        is_mul, is_div, start, div_signed;
  logic [31:0] rs_abs, rt_abs;
  logic [63:0] mul_a, mul_b, prod;
  logic [32:0] rem_shift, diff;
  logic        div_bit;
  logic [31:0] next_rem, next_quo, q_final, r_final;

  assign is_mul     = (funct == F_MULT) || (funct == F_MULTU);
  assign is_div     = (funct == F_DIV)  || (funct == F_DIVU);
  assign div_signed = (funct == F_DIV);
  assign start      = (state == S_IDLE) && md_valid && (is_mul || is_div);
  assign md_stall   = start || (state == S_MUL) || (state == S_DIV);

  assign rs_abs = (div_signed && rs_val[31]) ? -rs_val : rs_val;
  assign rt_abs = (div_signed && rt_val[31]) ? -rt_val : rt_val;

  // Sign- or zero-extend to 64 bits; the low 64 bits of the product are exact either way.
  assign mul_a = {{32{mul_signed & opa[31]}}, opa};
  assign mul_b = {{32{mul_signed & opb[31]}}, opb};
  assign prod  = mul_a * mul_b;

  // One restoring-division step; the final step feeds the sign fix-up directly.
  assign rem_shift = {rem, opa[31]};
  assign diff      = rem_shift - {1'b0, opb};
  assign div_bit   = ~diff[32];
  assign next_rem  = div_bit ? diff[31:0] : rem_shift[31:0];
  assign next_quo  = {opa[30:0], div_bit};
  assign q_final   = neg_q ? -next_quo : next_quo;
  assign r_final   = neg_r ? -next_rem : next_rem;

  always_comb begin
    mf_result = '0;
    if (funct == F_MFHI)      mf_result = hi;
    else if (funct == F_MFLO) mf_result = lo;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      opa         <= '0;
      opb         <= '0;
      rem         <= '0;
      mul_signed  <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
    end else begin
      div_by_zero <= 1'b0;
      case (state)
        S_IDLE: begin
          if (md_valid) begin
            case (funct)
              F_MTHI: hi <= rs_val;
              F_MTLO: lo <= rs_val;
              F_MULT, F_MULTU: begin
                opa        <= rs_val;
                opb        <= rt_val;
                mul_signed <= (funct == F_MULT);
                cnt        <= 5'(MUL_CYCLES - 1);
                state      <= S_MUL;
              end
              F_DIV, F_DIVU: begin
                if (rt_val == '0) begin
                  div_by_zero <= 1'b1;
                  state       <= S_DONE;
                end else begin
                  opa   <= rs_abs;
                  opb   <= rt_abs;
                  rem   <= '0;
                  neg_q <= div_signed && (rs_val[31] ^ rt_val[31]);
                  neg_r <= div_signed && rs_val[31];
                  cnt   <= 5'd31;
                  state <= S_DIV;
                end
              end
              default: ;
            endcase
          end
        end
        S_MUL: begin
          if (cnt == '0) begin
            hi    <= prod[63:32];
            lo    <= prod[31:0];
            state <= S_DONE;
          end else begin
            cnt <= cnt - 5'd1;
          end
        end
        S_DIV: begin
          opa <= next_quo;
          rem <= next_rem;
          if (cnt == '0) begin
            lo    <= q_final;
            hi    <= r_final;
            state <= S_DONE;
          end else begin
            cnt <= cnt - 5'd1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed-vector bench for ex_muldiv_unit with hand-computed HI/LO, stall lengths and pulses.
module tb_ex_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        md_valid = 1'b0;
  logic [5:0]  funct = '0;
  logic [31:0] rs_val = '0;
  logic [31:0] rt_val = '0;
  logic        md_stall;
  logic [31:0] hi, lo, mf_result;
  logic        div_by_zero;

  int n_tests = 0;
  int n_fail  = 0;
  int stalls;
  logic dbz;

  ex_muldiv_unit #(.MUL_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .md_valid(md_valid), .funct(funct),
    .rs_val(rs_val), .rt_val(rt_val), .md_stall(md_stall), .hi(hi), .lo(lo),
    .mf_result(mf_result), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Present one instruction in EX and hold it until the stall drops (hazard-unit behaviour),
  // then let it leave EX on the following edge. Entered and left at #1 after a rising edge.
  task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        output int n_stall, output logic dbz_o);
    md_valid = 1'b1; funct = f; rs_val = a; rt_val = b;
    n_stall = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!md_stall) break;
      n_stall++;
      @(posedge clk); #1;
    end
    dbz_o = div_by_zero;
    @(posedge clk); #1;
    md_valid = 1'b0; funct = '0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    check("rst_stall", {31'b0, md_stall}, 32'h0);
    check("rst_dbz", {31'b0, div_by_zero}, 32'h0);
    reset = 1'b1;
    @(posedge clk); #1;

    run_op(6'h18, 32'hFFFF_FFFF, 32'h2, stalls, dbz);
    check("mult_stall", stalls, 32'd5);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFFE);

    run_op(6'h19, 32'hFFFF_FFFF, 32'h2, stalls, dbz);
    check("multu_stall", stalls, 32'd5);
    check("multu_hi", hi, 32'h0000_0001);
    check("multu_lo", lo, 32'hFFFF_FFFE);

    run_op(6'h1A, 32'hFFFF_FFF9, 32'h2, stalls, dbz);
    check("div_stall", stalls, 32'd33);
    check("div_lo", lo, 32'hFFFF_FFFD);
    check("div_hi", hi, 32'hFFFF_FFFF);
    check("div_dbz", {31'b0, dbz}, 32'h0);

    run_op(6'h1B, 32'd100, 32'd7, stalls, dbz);
    check("divu_stall", stalls, 32'd33);
    check("divu_lo", lo, 32'd14);
    check("divu_hi", hi, 32'd2);

    run_op(6'h1A, 32'h8000_0000, 32'hFFFF_FFFF, stalls, dbz);
    check("divovf_lo", lo, 32'h8000_0000);
    check("divovf_hi", hi, 32'h0);

    run_op(6'h11, 32'h1234, 32'h0, stalls, dbz);
    check("mthi_stall", stalls, 32'd0);
    check("mthi_hi", hi, 32'h1234);
    run_op(6'h13, 32'h5678, 32'h0, stalls, dbz);
    check("mtlo_lo", lo, 32'h5678);

    run_op(6'h1A, 32'd5, 32'd0, stalls, dbz);
    check("div0_stall", stalls, 32'd1);
    check("div0_pulse", {31'b0, dbz}, 32'h1);
    check("div0_pulse_end", {31'b0, div_by_zero}, 32'h0);
    check("div0_hi", hi, 32'h1234);
    check("div0_lo", lo, 32'h5678);

    md_valid = 1'b1; funct = 6'h10; #1;
    check("mfhi", mf_result, 32'h1234);
    check("mfhi_stall", {31'b0, md_stall}, 32'h0);
    funct = 6'h12; #1;
    check("mflo", mf_result, 32'h5678);
    funct = 6'h20; #1;
    check("other_mf", mf_result, 32'h0);
    check("other_stall", {31'b0, md_stall}, 32'h0);
    md_valid = 1'b0; funct = 6'h18; #1;
    check("novalid_stall", {31'b0, md_stall}, 32'h0);
    @(posedge clk); #1;
    check("other_hi", hi, 32'h1234);

    // Reset in the 10th division iteration; the pipeline flush drops md_valid with it.
    md_valid = 1'b1; funct = 6'h1A; rs_val = 32'hFFFF_FFF9; rt_val = 32'h2;
    @(posedge clk); #1;
    repeat (9) begin @(posedge clk); #1; end
    check("mid_stall_pre", {31'b0, md_stall}, 32'h1);
    md_valid = 1'b0; funct = '0;
    reset = 1'b0; #1;
    check("midrst_stall", {31'b0, md_stall}, 32'h0);
    check("midrst_hi", hi, 32'h0);
    check("midrst_lo", lo, 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("post_rst_stall", {31'b0, md_stall}, 32'h0);

    run_op(6'h18, 32'd3, 32'd5, stalls, dbz);
    check("mult35_stall", stalls, 32'd5);
    check("mult35_hi", hi, 32'h0);
    check("mult35_lo", lo, 32'd15);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
